sdram_arbiter_rr: RTL and testbench

Round-robin arbiter sharing the single SDRAM/framebuffer master port between N rendering and scan-out requesters (sample, grid, text renderers, display fetch). It sits between the `disp_*` draw blocks and the memory controller, using the same req/ack handshake on both sides. It also supports bounded same-requester bursts and routes in-order read data back to the issuing requester through a small ID FIFO.

---
 rtl/sdram_arbiter_rr_if.sv | 36 +++
 rtl/sdram_arbiter_rr.sv | 150 +++++++++++++++
 tb/tb_sdram_arbiter_rr.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_rr_if.sv
// Requester-side and memory-side signals of the SDRAM round-robin arbiter.
// slave = arbiter view, master = requesters plus memory controller view.
interface sdram_arbiter_rr_if #(
  parameter int N  = 4,
  parameter int AW = 24,
  parameter int DW = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic [N-1:0]    wr;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            mem_wr;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic [IW-1:0]   gnt_id;
  logic            err;

  modport slave (
    input  req, addr, data, wr, mem_ack, mem_rvalid, mem_rdata,
    output ack, rvalid, rdata, mem_req, mem_addr, mem_data, mem_wr, gnt_id, err
  );

  modport master (
    output req, addr, data, wr, mem_ack, mem_rvalid, mem_rdata,
    input  ack, rvalid, rdata, mem_req, mem_addr, mem_data, mem_wr, gnt_id, err
  );
endinterface

// File: rtl/sdram_arbiter_rr.sv
// Round-robin SDRAM port arbiter with bounded bursts and in-order read-return routing via an ID FIFO.
// Grant one cycle after req, ack same cycle as mem_ack; reads stall when OUTSTD are in flight. SDRAM_ARB_PRIO0_EN: requester 0 fixed priority.
module sdram_arbiter_rr #(
  parameter int N      = 4,
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int BURST  = 4,
  parameter int OUTSTD = 4
) (
  input  logic               clkSYS,
  input  logic               reset,
  sdram_arbiter_rr_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
  localparam int QW = $clog2(OUTSTD + 1);
  localparam logic [CW-1:0] BMAX   = CW'(BURST - 1);
  localparam logic [QW-1:0] QFULL  = QW'(OUTSTD);
  localparam logic [IW-1:0] LASTID = IW'(N - 1);
  localparam logic [N-1:0]  ONE    = N'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [IW-1:0] r_gnt_id;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_burst_cnt;
  logic          r_prev_acked;
  logic [IW-1:0] r_fifo [OUTSTD];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [QW-1:0] r_cnt;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic [N-1:0]  w_elig;
  logic          w_prio;
  logic          w_any;
  logic [IW-1:0] w_sel;
  logic [CW-1:0] w_burst_next;
  int            w_j;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_cnt == QFULL);
  assign w_empty = (r_cnt == '0);
  // Reads need a free ID slot; writes never return data so they are always eligible.
  assign w_elig  = bus.req & (bus.wr | {N{~w_full}});

`ifdef SDRAM_ARB_PRIO0_EN
  assign w_prio = w_elig[0];
`else
  assign w_prio = 1'b0;
`endif

  always_comb begin
    w_sel        = r_last;
    w_burst_next = '0;
    w_any        = 1'b0;
    w_j          = 0;
    if (w_prio) begin
      w_sel = '0;
      w_any = 1'b1;
    end else if (w_elig[r_last] && (r_burst_cnt < BMAX) && r_prev_acked) begin
      w_sel        = r_last;
      w_burst_next = r_burst_cnt + CW'(1);
      w_any        = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        w_j = int'(r_last) + k;
        if (w_j >= N) w_j = w_j - N;
        if (!w_any && w_elig[IW'(w_j)]) begin
          w_sel = IW'(w_j);
          w_any = 1'b1;
        end
      end
    end
  end

  assign w_grant = (r_state == S_GRANT);
  assign w_push  = w_grant && bus.mem_ack && !bus.mem_wr;
  assign w_pop   = bus.mem_rvalid && !w_empty;

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_gnt_id     <= '0;
      r_last       <= LASTID;
      r_burst_cnt  <= '0;
      r_prev_acked <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < OUTSTD; i++) r_fifo[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_GRANT;
            r_mem_req   <= 1'b1;
            r_gnt_id    <= w_sel;
            r_last      <= w_sel;
            r_burst_cnt <= w_burst_next;
          end
        end
        S_GRANT: begin
          if (bus.mem_ack) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_prev_acked <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase

      if (w_push) begin
        r_fifo[r_wp] <= r_gnt_id;
        r_wp         <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + QW'(1);
        2'b01:   r_cnt <= r_cnt - QW'(1);
        default: r_cnt <= r_cnt;
      endcase

      // A return with nothing outstanding means the controller and arbiter disagree.
      if (bus.mem_rvalid && w_empty) r_err <= 1'b1;
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.err      = r_err;
  assign bus.mem_addr = bus.addr[int'(r_gnt_id)*AW +: AW];
  assign bus.mem_data = bus.data[int'(r_gnt_id)*DW +: DW];
  assign bus.mem_wr   = bus.wr[r_gnt_id];
  assign bus.ack      = (w_grant && bus.mem_ack) ? (ONE << r_gnt_id) : '0;
  assign bus.rvalid   = w_pop ? (ONE << r_fifo[r_rp]) : '0;
  assign bus.rdata    = bus.mem_rdata;
endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Bench for sdram_arbiter_rr: directed scenarios plus randomized traffic, all checked cycle by cycle
// against a queue-based model of the arbitration and read-return rules.
module tb_sdram_arbiter_rr;
  localparam int N = 4, AW = 24, DW = 16, BURST = 4, OUTSTD = 4;
  localparam logic [N-1:0] ONE = N'(1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_arbiter_rr_if #(.N(N), .AW(AW), .DW(DW)) bus();

  sdram_arbiter_rr #(.N(N), .AW(AW), .DW(DW), .BURST(BURST), .OUTSTD(OUTSTD)) dut (
    .clkSYS (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit           m_busy;
  int           m_gnt;
  int           m_last;
  int           m_burst;
  bit           m_prev_ack;
  bit           m_err;
  int           m_q[$];
  logic [N-1:0] m_ack;

  // Observations of the DUT for directed scenario checks
  int           cyc_no;
  int           o_mreq_cnt;
  int           o_gnt_log[$];
  int           o_ack_cyc[$];
  int           o_ack_cnt[N];
  logic [AW-1:0] o_last_addr;
  logic         o_last_wr;

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_last = N - 1; m_burst = 0;
    m_prev_ack = 0; m_err = 0; m_q.delete(); m_ack = '0;
  endtask

  task automatic clear_obs();
    o_mreq_cnt = 0; o_gnt_log.delete(); o_ack_cyc.delete();
    foreach (o_ack_cnt[i]) o_ack_cnt[i] = 0;
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_ack, e_rv;
    e_ack = (m_busy && bus.mem_ack) ? (ONE << m_gnt) : '0;
    e_rv  = (bus.mem_rvalid && m_q.size() > 0) ? (ONE << m_q[0]) : '0;
    chk("mem_req", 32'(bus.mem_req), 32'(m_busy));
    chk("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
    chk("err", 32'(bus.err), 32'(m_err));
    if (e_rv != '0) chk("rdata", 32'(bus.rdata), 32'(bus.mem_rdata));
    if (m_busy) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(bus.addr[m_gnt*AW +: AW]));
      chk("mem_data", 32'(bus.mem_data), 32'(bus.data[m_gnt*DW +: DW]));
      chk("mem_wr", 32'(bus.mem_wr), 32'(bus.wr[m_gnt]));
    end
    if (bus.mem_req === 1'b1) begin
      o_mreq_cnt++;
      o_last_addr = bus.mem_addr;
      o_last_wr   = bus.mem_wr;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i] === 1'b1) begin
        o_gnt_log.push_back(i);
        o_ack_cyc.push_back(cyc_no);
        o_ack_cnt[i]++;
      end
    end
    m_ack = e_ack;
  endtask

  // Next-state rules: one transfer at a time, burst continuation, otherwise next eligible after last.
  task automatic model_update();
    logic [N-1:0] el;
    int sz, sel;
    bit found;
    if (reset) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    if (bus.mem_rvalid) begin
      if (sz > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (m_busy) begin
      if (bus.mem_ack) begin
        m_busy = 0;
        m_prev_ack = 1;
        if (!bus.wr[m_gnt]) m_q.push_back(m_gnt);
      end
    end else begin
      for (int i = 0; i < N; i++) el[i] = bus.req[i] && (bus.wr[i] || sz < OUTSTD);
      found = 0;
      sel = 0;
`ifdef SDRAM_ARB_PRIO0_EN
      if (el[0]) begin sel = 0; m_burst = 0; found = 1; end
`endif
      if (!found && el[m_last] && m_burst < BURST - 1 && m_prev_ack) begin
        sel = m_last; m_burst++; found = 1;
      end
      for (int k = 1; k <= N; k++) begin
        if (!found && el[(m_last + k) % N]) begin
          sel = (m_last + k) % N; m_burst = 0; found = 1;
        end
      end
      if (found) begin m_busy = 1; m_gnt = sel; m_last = sel; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_update();
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.wr[i]  = w;
    bus.addr[i*AW +: AW] = a;
    bus.data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.req = '0;
    tick();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic do_one(input int i, input logic w, input logic [AW-1:0] a);
    int start, c;
    start = o_ack_cnt[i];
    c = 0;
    set_req(i, w, a, DW'(a));
    while (o_ack_cnt[i] == start && c < 10) begin tick(); c++; end
    bus.req[i] = 1'b0;
    chk("one_acked", 32'(o_ack_cnt[i]), 32'(start + 1));
  endtask

  initial begin
    int mb, c;
    int exp_order[9];
    logic [DW-1:0] pat[3];
    logic [N-1:0] rexp[3];
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    pat  = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    rexp = '{4'b0010, 4'b0100, 4'b0010};
    cyc_no = 0;

    reset = 1'b1;
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.data = '0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    // Single requester, controller acks on the fourth grant cycle
    do_reset();
    set_req(2, 1'b1, 24'h000123, 16'h5A5A);
    mb = 0;
    repeat (12) begin
      if (m_ack[2]) bus.req[2] = 1'b0;
      bus.mem_ack = m_busy && (mb == 3);
      if (m_busy) mb++;
      tick();
    end
    chk("t1_mreq_cycles", 32'(o_mreq_cnt), 32'd4);
    chk("t1_ack2", 32'(o_ack_cnt[2]), 32'd1);
    chk("t1_acks", 32'(o_gnt_log.size()), 32'd1);
    chk("t1_gnt", 32'(bus.gnt_id), 32'd2);
    chk("t1_addr", 32'(o_last_addr), 32'h000123);
    chk("t1_wr", 32'(o_last_wr), 32'd1);

    // Burst cap and rotation with a zero-wait controller
    do_reset();
    set_req(0, 1'b1, 24'h000A00, 16'h0A0A);
    set_req(1, 1'b1, 24'h000B00, 16'h0B0B);
    bus.mem_ack = 1'b1;
    c = 0;
    while (o_gnt_log.size() < 9 && c < 60) begin tick(); c++; end
    chk("t2_count", 32'(o_gnt_log.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < o_gnt_log.size(); i++) chk("t2_order", 32'(o_gnt_log[i]), 32'(exp_order[i]));
    for (int i = 1; i < 9 && i < o_ack_cyc.size(); i++) chk("t2_spacing", 32'(o_ack_cyc[i] - o_ack_cyc[i-1]), 32'd2);
    bus.req = '0;

    // ID FIFO full blocks reads but not writes
    do_reset();
    bus.mem_ack = 1'b1;
    set_req(3, 1'b0, 24'h000300, 16'h0);
    repeat (14) tick();
    chk("t3_ack3_full", 32'(o_ack_cnt[3]), 32'd4);
    set_req(1, 1'b1, 24'h000100, 16'h1111);
    c = 0;
    while (o_ack_cnt[1] < 1 && c < 10) begin tick(); c++; end
    bus.req[1] = 1'b0;
    chk("t3_wr1", 32'(o_ack_cnt[1]), 32'd1);
    chk("t3_ack3_blocked", 32'(o_ack_cnt[3]), 32'd4);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'h3333;
    #1;
    chk("t3_rvalid", 32'(bus.rvalid), 32'b1000);
    chk("t3_rdata", 32'(bus.rdata), 32'h3333);
    tick();
    bus.mem_rvalid = 1'b0;
    c = 0;
    while (o_ack_cnt[3] < 5 && c < 6) begin tick(); c++; end
    bus.req[3] = 1'b0;
    chk("t3_fifth", 32'(o_ack_cnt[3]), 32'd5);

    // Read routing back to issuers in order
    do_reset();
    bus.mem_ack = 1'b1;
    do_one(1, 1'b0, 24'h000111);
    do_one(2, 1'b0, 24'h000222);
    do_one(1, 1'b0, 24'h000333);
    bus.mem_ack = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = pat[j];
      #1;
      chk("t4_rvalid", 32'(bus.rvalid), 32'(rexp[j]));
      chk("t4_rdata", 32'(bus.rdata), 32'(pat[j]));
      tick();
    end
    bus.mem_rvalid = 1'b0;

    // Spurious return sets err; reset mid-grant clears everything
    do_reset();
    bus.mem_rvalid = 1'b1;
    #1;
    chk("t5_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("t5_err", 32'(bus.err), 32'd1);
    set_req(0, 1'b1, 24'h000777, 16'h7777);
    c = 0;
    while (!m_busy && c < 5) begin tick(); c++; end
    chk("t5_grant", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_mreq_rst", 32'(bus.mem_req), 32'd0);
    chk("t5_err_rst", 32'(bus.err), 32'd0);

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
      end
      bus.mem_ack    = ($urandom_range(0, 2) != 0);
      bus.mem_rvalid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      bus.mem_rdata  = DW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
